// File: rtl/ifcfg_loader.sv
// ifcfg_loader
//   Responder side of the CCU configuration handshake. When the CCU raises
//   CFG_Req, the loader pulls CFG_WORDS words from the off-chip IF stream,
//   stores them in configuration registers, and reports completion.
//   The packed configuration drives the PE array and the GBF control.
//
// Ports
//   clk, rst_n     clock and asynchronous active-low reset
//   CFG_Req        CCU level request; high while the CCU is in CFG
//   IF_Dat         configuration word from the off-chip IF
//   IF_DatVal      IF_Dat is valid
//   IFCFG_Rdy      ready; a word is accepted on IF_DatVal && IFCFG_Rdy
//   IFCFG_RdDone   one-cycle pulse once all CFG_WORDS words are loaded
//   IFCFG_Val      configuration registers hold a complete configuration
//   IFCFG_Cnt      number of words accepted in the current load
//   CFG_Bus        packed configuration; word i at [i*DATA_WIDTH +: DATA_WIDTH]
module ifcfg_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int CFG_WORDS  = 8,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            CFG_Req,
  input  logic [DATA_WIDTH-1:0]           IF_Dat,
  input  logic                            IF_DatVal,
  output logic                            IFCFG_Rdy,
  output logic                            IFCFG_RdDone,
  output logic                            IFCFG_Val,
  output logic [CNT_WIDTH-1:0]            IFCFG_Cnt,
  output logic [CFG_WORDS*DATA_WIDTH-1:0] CFG_Bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    DONE    = 2'd2,
    WAITLOW = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(CFG_WORDS - 1);

  state_t                r_state;
  state_t                w_nxt;
  logic                  w_rdy;
  logic                  w_hs;      // accepted word this cycle
  logic                  w_start;   // IDLE -> LOAD
  logic                  w_abort;   // request dropped mid-load
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_val;
  logic                  r_rddone;

  // ---------------------------------------------------------------------------
  // Next-state / decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_nxt   = r_state;
    w_rdy   = 1'b0;
    w_hs    = 1'b0;
    w_start = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      IDLE: begin
        if (CFG_Req) begin
          w_start = 1'b1;
          w_nxt   = LOAD;
        end
      end
      LOAD: begin
        w_rdy = 1'b1;
        // A dropped request wins over a same-cycle word; that word is lost.
        if (!CFG_Req) begin
          w_abort = 1'b1;
          w_nxt   = IDLE;
        end else if (IF_DatVal) begin
          w_hs = 1'b1;
          if (r_cnt == LAST_IDX) w_nxt = DONE;
        end
      end
      DONE:    w_nxt = WAITLOW;
      // Holding the request here keeps a finished config from being reloaded;
      // the CCU must drop and re-raise CFG_Req to start over.
      WAITLOW: if (!CFG_Req) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  assign IFCFG_Rdy = w_rdy;

  // ---------------------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_val    <= 1'b0;
      r_rddone <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      // Pulse is high exactly for the single DONE cycle.
      r_rddone <= (w_nxt == DONE);

      if (w_start || w_abort)
        r_cnt <= '0;
      else if (w_hs)
        r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + CNT_WIDTH'(1);

      // Val holds through WAITLOW and IDLE until the next load begins.
      if (w_start)
        r_val <= 1'b0;
      else if (r_state == DONE)
        r_val <= 1'b1;
    end
  end

  assign IFCFG_Cnt    = r_cnt;
  assign IFCFG_Val    = r_val;
  assign IFCFG_RdDone = r_rddone;

  // ---------------------------------------------------------------------------
  // Configuration word registers; only written on LOAD handshakes so the bus
  // is stable whenever IFCFG_Val is set.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < CFG_WORDS; gi++) begin : g_word
    logic [DATA_WIDTH-1:0] r_word;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_word <= '0;
      else if (w_hs && (r_cnt == CNT_WIDTH'(gi)))
        r_word <= IF_Dat;
    end
    assign CFG_Bus[gi*DATA_WIDTH +: DATA_WIDTH] = r_word;
  end

endmodule

// File: tb/tb_ifcfg_loader.sv
// Directed testbench for ifcfg_loader (DATA_WIDTH=32, CFG_WORDS=8).
module tb_ifcfg_loader;

  localparam int DW = 32;
  localparam int NW = 8;
  localparam int CW = 3;

  logic                clk;
  logic                rst_n;
  logic                CFG_Req;
  logic [DW-1:0]       IF_Dat;
  logic                IF_DatVal;
  logic                IFCFG_Rdy;
  logic                IFCFG_RdDone;
  logic                IFCFG_Val;
  logic [CW-1:0]       IFCFG_Cnt;
  logic [NW*DW-1:0]    CFG_Bus;

  int n_cmp = 0;
  int n_bad = 0;

  ifcfg_loader #(.DATA_WIDTH(DW), .CFG_WORDS(NW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .CFG_Req      (CFG_Req),
    .IF_Dat       (IF_Dat),
    .IF_DatVal    (IF_DatVal),
    .IFCFG_Rdy    (IFCFG_Rdy),
    .IFCFG_RdDone (IFCFG_RdDone),
    .IFCFG_Val    (IFCFG_Val),
    .IFCFG_Cnt    (IFCFG_Cnt),
    .CFG_Bus      (CFG_Bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NW*DW-1:0] obs,
                     input logic [NW*DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NW*DW-1:0] bus_of(input logic [DW-1:0] base);
    logic [NW*DW-1:0] b;
    b = '0;
    for (int i = 0; i < NW; i++) b[i*DW +: DW] = base + DW'(i);
    return b;
  endfunction

  // From LOAD, push NW back-to-back words base..base+7; ends in DONE.
  task automatic load_burst(input string tag, input logic [DW-1:0] base);
    for (int i = 0; i < NW; i++) begin
      chk({tag, "_rdy"}, {255'd0, IFCFG_Rdy}, 256'd1);
      IF_DatVal = 1'b1;
      IF_Dat    = base + DW'(i);
      tick();
      if (i < NW - 1) begin
        chk({tag, "_cnt"}, 256'(IFCFG_Cnt), 256'(i + 1));
        chk({tag, "_nodone"}, {255'd0, IFCFG_RdDone}, 256'd0);
      end
    end
    IF_DatVal = 1'b0;
    chk({tag, "_rddone"}, {255'd0, IFCFG_RdDone}, 256'd1);
    chk({tag, "_cntwrap"}, 256'(IFCFG_Cnt), 256'd0);
    chk({tag, "_valdone"}, {255'd0, IFCFG_Val}, 256'd0);
  endtask

  initial begin
    int exp_cnt;
    logic held_ok;

    rst_n = 1'b0; CFG_Req = 1'b0; IF_Dat = '0; IF_DatVal = 1'b0;
    #12;
    chk("rst_rdy",  {255'd0, IFCFG_Rdy},    256'd0);
    chk("rst_done", {255'd0, IFCFG_RdDone}, 256'd0);
    chk("rst_val",  {255'd0, IFCFG_Val},    256'd0);
    chk("rst_cnt",  256'(IFCFG_Cnt),        256'd0);
    chk("rst_bus",  CFG_Bus,                256'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_rdy", {255'd0, IFCFG_Rdy}, 256'd0);

    // ---- basic load 0x10..0x17
    CFG_Req = 1'b1;
    tick();
    chk("b_val_entry", {255'd0, IFCFG_Val}, 256'd0);
    load_burst("b", 32'h10);
    tick();                                   // WAITLOW
    chk("b_val",  {255'd0, IFCFG_Val},    256'd1);
    chk("b_pulse",{255'd0, IFCFG_RdDone}, 256'd0);
    chk("b_bus",  CFG_Bus, bus_of(32'h10));

    // ---- held request: no reload for 20 cycles
    held_ok = 1'b1;
    IF_DatVal = 1'b1; IF_Dat = 32'hDEAD;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (IFCFG_Rdy || !IFCFG_Val || IFCFG_RdDone) held_ok = 1'b0;
    end
    IF_DatVal = 1'b0;
    chk("held_quiet", {255'd0, held_ok}, 256'd1);
    chk("held_bus", CFG_Bus, bus_of(32'h10));

    // ---- drop, re-raise, load with valid gaps 0x20..0x27
    CFG_Req = 1'b0;
    tick();                                   // IDLE
    chk("idle_val_kept", {255'd0, IFCFG_Val}, 256'd1);
    CFG_Req = 1'b1;
    tick();                                   // LOAD
    chk("g_val_clear", {255'd0, IFCFG_Val}, 256'd0);
    exp_cnt = 0;
    for (int j = 0; j < 15; j++) begin
      IF_DatVal = (j % 2 == 0);
      IF_Dat    = (j % 2 == 0) ? 32'h20 + DW'(j / 2) : 32'hBAD0 + DW'(j);
      tick();
      if (j % 2 == 0) exp_cnt = (exp_cnt + 1) % NW;
      chk("g_cnt", 256'(IFCFG_Cnt), 256'(exp_cnt));
      chk("g_done", {255'd0, IFCFG_RdDone}, (j == 14) ? 256'd1 : 256'd0);
    end
    IF_DatVal = 1'b0;
    CFG_Req   = 1'b0;
    tick();                                   // WAITLOW
    tick();                                   // IDLE
    chk("g_bus", CFG_Bus, bus_of(32'h20));
    chk("g_val", {255'd0, IFCFG_Val}, 256'd1);

    // ---- abort after 3 words; dropped request beats a same-cycle word
    CFG_Req = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      IF_DatVal = 1'b1; IF_Dat = 32'h30 + DW'(i);
      tick();
    end
    chk("a_cnt3", 256'(IFCFG_Cnt), 256'd3);
    CFG_Req = 1'b0; IF_Dat = 32'h33;          // IF_DatVal still 1
    tick();
    IF_DatVal = 1'b0;
    chk("a_cnt0", 256'(IFCFG_Cnt), 256'd0);
    chk("a_val",  {255'd0, IFCFG_Val}, 256'd0);
    chk("a_rdy",  {255'd0, IFCFG_Rdy}, 256'd0);
    tick();
    chk("a_stay_idle", {255'd0, IFCFG_Rdy}, 256'd0);

    // ---- re-request, load 0xA0..0xA7, CCU leaves CFG the cycle after RdDone
    CFG_Req = 1'b1;
    tick();
    load_burst("r", 32'hA0);
    CFG_Req = 1'b0;
    tick();                                   // WAITLOW
    chk("ccu_pulse_once", {255'd0, IFCFG_RdDone}, 256'd0);
    tick();                                   // IDLE
    chk("ccu_val",  {255'd0, IFCFG_Val}, 256'd1);
    chk("ccu_rdy",  {255'd0, IFCFG_Rdy}, 256'd0);
    chk("ccu_bus",  CFG_Bus, bus_of(32'hA0));
    held_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (IFCFG_RdDone || !IFCFG_Val) held_ok = 1'b0;
    end
    chk("ccu_no_repeat", {255'd0, held_ok}, 256'd1);

    // ---- async reset at word 5
    CFG_Req = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      IF_DatVal = 1'b1; IF_Dat = 32'h40 + DW'(i);
      tick();
    end
    IF_DatVal = 1'b0;
    chk("r_cnt5", 256'(IFCFG_Cnt), 256'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rdy", {255'd0, IFCFG_Rdy}, 256'd0);
    chk("ar_val", {255'd0, IFCFG_Val}, 256'd0);
    chk("ar_cnt", 256'(IFCFG_Cnt),     256'd0);
    chk("ar_bus", CFG_Bus,             256'd0);
    #3 rst_n = 1'b1;
    tick();                                   // IDLE sees CFG_Req -> LOAD
    load_burst("p", 32'h50);
    tick();
    chk("p_val", {255'd0, IFCFG_Val}, 256'd1);
    chk("p_bus", CFG_Bus, bus_of(32'h50));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
